// File: rtl/sha1_pkg.sv
// Shared types and constants for the SHA-1 padder and its surrounding top level.
package sha1_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_t;

  localparam logic [31:0]  PAD_WORD     = 32'h8000_0000;
  localparam logic [4:0]   LEN_HI_IDX   = 5'd14;
  localparam logic [4:0]   LEN_LO_IDX   = 5'd15;
  localparam logic [159:0] SHA1_INIT_CV =
    160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

endpackage

// File: rtl/sha1_pad_word.sv
// Masks the final message word to its valid bytes and appends the 0x80 pad byte.
module sha1_pad_word
  import sha1_pkg::*;
(
  input  logic [31:0] data,
  input  logic [2:0]  bytes,
  output logic [31:0] word
);

  // A count of 4 (or anything unexpected) leaves the word untouched; the pad
  // byte then goes into the following word.
  always_comb begin
    case (bytes)
      3'd0:    word = PAD_WORD;
      3'd1:    word = {data[31:24], 24'h80_0000};
      3'd2:    word = {data[31:16], 16'h8000};
      3'd3:    word = {data[31:8], 8'h80};
      default: word = data;
    endcase
  end

endmodule

// File: rtl/sha1_padder.sv
// FIPS 180 padder feeding sha1_exec one 512-bit block at a time.
// Optional build macro SHA1_PAD_EMPTY_MSG_EN enables zero-byte messages (in_bytes=0 on the last beat).
module sha1_padder
  import sha1_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic [2:0]  in_bytes,
  output logic [31:0] core_data,
  output logic        core_load,
  output logic        core_start,
  output logic        core_use_prev_cv,
  input  logic        core_out_valid,
  output logic        msg_done
);

  state_t           state;
  logic [4:0]       word_idx;
  logic [LEN_W-1:0] bit_len;
  logic             first_block;
  logic             pad_done;
  logic             pad_pending;
  logic             spill;

  logic [2:0]       eff_bytes;
  logic [31:0]      last_word;
  logic [63:0]      len64;
  logic             accept;
  logic             last_block;

  always_comb begin
    eff_bytes = 3'd4;
    if (in_last) begin
      case (in_bytes)
        3'd1, 3'd2, 3'd3: eff_bytes = in_bytes;
`ifdef SHA1_PAD_EMPTY_MSG_EN
        3'd0:             eff_bytes = 3'd0;
`endif
        default:          eff_bytes = 3'd4;
      endcase
    end
  end

  always_comb begin
    len64 = '0;
    len64[LEN_W-1:0] = bit_len;
  end

  sha1_pad_word u_pad_word (
    .data  (in_data),
    .bytes (eff_bytes),
    .word  (last_word)
  );

  // Gated by reset_n so the port reads 0 while reset is held.
  assign in_ready   = reset_n && (state == IDLE || state == LOAD) && !pad_done
                      && (word_idx < 5'd16);
  assign accept     = in_valid && in_ready;
  // A block is final once the pad byte is placed and the length fits after it.
  assign last_block = pad_done && !pad_pending && !spill;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      word_idx         <= '0;
      bit_len          <= '0;
      first_block      <= 1'b1;
      pad_done         <= 1'b0;
      pad_pending      <= 1'b0;
      spill            <= 1'b0;
      core_data        <= '0;
      core_load        <= 1'b0;
      core_start       <= 1'b0;
      core_use_prev_cv <= 1'b0;
      msg_done         <= 1'b0;
    end else begin
      core_load <= 1'b0;
      msg_done  <= 1'b0;
      case (state)
        IDLE, LOAD: begin
          if (accept) begin
            state     <= LOAD;
            core_load <= 1'b1;
            core_data <= in_last ? last_word : in_data;
            word_idx  <= word_idx + 5'd1;
            bit_len   <= bit_len + (LEN_W'(eff_bytes) << 3);
            if (in_last) begin
              pad_done <= 1'b1;
              if (eff_bytes == 3'd4) pad_pending <= 1'b1;
              else                   spill       <= (word_idx >= LEN_HI_IDX);
            end
          end else if (state == LOAD && pad_done && word_idx < 5'd16) begin
            core_load <= 1'b1;
            word_idx  <= word_idx + 5'd1;
            if (pad_pending) begin
              core_data   <= PAD_WORD;
              pad_pending <= 1'b0;
              spill       <= (word_idx >= LEN_HI_IDX);
            end else if (!spill && word_idx == LEN_HI_IDX) begin
              core_data <= len64[63:32];
            end else if (!spill && word_idx == LEN_LO_IDX) begin
              core_data <= len64[31:0];
            end else begin
              core_data <= '0;
            end
          end else if (state == LOAD && word_idx == 5'd16) begin
            state            <= START;
            core_start       <= 1'b1;
            core_use_prev_cv <= !first_block;
          end
        end
        START: begin
          core_start       <= 1'b0;
          core_use_prev_cv <= 1'b0;
          state            <= WAIT;
        end
        WAIT: begin
          if (core_out_valid) begin
            word_idx <= '0;
            spill    <= 1'b0;
            if (last_block) begin
              msg_done    <= 1'b1;
              pad_done    <= 1'b0;
              bit_len     <= '0;
              first_block <= 1'b1;
              state       <= IDLE;
            end else begin
              first_block <= 1'b0;
              state       <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sha1_padder.md
Name: sha1_padder

Overview:
Upstream feeder for the SHA-1 compression core (sha1_exec). Accepts a message as a stream of 32-bit big-endian words with a valid/ready handshake. Applies FIPS 180 padding: 0x80 byte, zero fill, then the 64-bit bit-length. Drives the core's word-load/start/use_prev_cv interface one 512-bit block at a time, waiting for core completion between blocks.

Parameters:
LEN_W, 64, width of the message bit-length counter. Values below 64 are zero-extended into the length field; LEN_W is always a multiple of 8 and ≤ 64.

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  input word valid
in_ready  out  1  padder accepts a word this cycle
in_data  in  32  message word; first byte in [31:24]
in_last  in  1  final word of message
in_bytes  in  3  valid bytes on the last beat (1..4); ignored when in_last=0
core_data  out  32  word to core (data_in)
core_load  out  1  core word strobe (load_in)
core_start  out  1  one-cycle block start (start)
core_use_prev_cv  out  1  chain previous CV; valid with core_start
core_out_valid  in  1  core block finished
msg_done  out  1  one-cycle pulse: final block's core_out_valid seen

Behaviour:
- Reset (async, reset_n=0): state IDLE. All outputs 0 except in_ready=0. Word index 0, byte count 0, first_block=1, pad_done=0.
- States:
  - LOAD: collect or generate words.
  - START: core_start=1 for one cycle.
  - WAIT: hold until core_out_valid.
  - IDLE: wait for the first beat, then enter LOAD.
- in_ready=1 only in IDLE or LOAD, when pad_done=0 and word index < 16. A beat transfers when in_valid & in_ready.
- Each accepted or generated word is registered. It appears on core_data with core_load=1 on the next cycle (latency 1).
- Holes in in_valid produce no load cycle, and the word index holds.
- Last beat with in_bytes=n:
  - n<4: emitted word = n data bytes, then 0x80, then zero bytes. Set pad_done.
  - n=4: data word unmodified. The next generated word is 0x80000000. Set pad_done.
- After pad_done, the padder self-generates words at one per cycle:
  - zeros until index 14;
  - index 14 = length[63:32];
  - index 15 = length[31:0].
- Spill rule: if the pad byte lands in word 14 or 15, fill the rest of that block with zeros. The next block is zeros through index 13, then the length words.
- Length field = 8 × total accepted bytes, modulo 2^LEN_W, counted over the whole message.
- After index 15 loads, go to START. The cycle after the final core_load, assert core_start with core_use_prev_cv = !first_block, then go to WAIT.
- WAIT: in_ready=0. On core_out_valid:
  - if the last block of the message was just processed: pulse msg_done, reset the counters, first_block=1, go to IDLE;
  - otherwise: first_block=0, word index 0, go to LOAD.
- Simultaneous in_valid and core_out_valid in WAIT: the beat is not accepted that cycle (in_ready=0).
- core_out_valid outside WAIT: ignored.
- Reset mid-operation: abort immediately, no msg_done.

Optional Feature:
SHA1_PAD_EMPTY_MSG_EN.
- Defined: an in_last beat with in_bytes=0 is a zero-byte message. The padder emits 0x80000000, zeros, and length 0 in one block.
- Undefined: in_bytes=0 on the last beat is treated as 4.

Decomposition:
- Shared package sha1_pkg holds:
  - state enum (IDLE, LOAD, START, WAIT);
  - PAD_WORD = 32'h80000000;
  - LEN_HI_IDX = 14, LEN_LO_IDX = 15;
  - the initial-CV constant 67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0 for the surrounding top level.
- One natural sub-module: sha1_pad_word. Combinational; takes in_data and in_bytes and returns the masked word with the 0x80 byte inserted.

Test Plan:
- "abc" (one beat 0x61626300, in_last, in_bytes=3) → loads 0x61626380, 13×0, 0x00000000, 0x00000018. core_start with use_prev_cv=0. With sha1_exec attached, CV = a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d; msg_done pulses once.
- 56-byte "abcdbcdecdef…nopq" (14 full beats) → block 1 ends with 0x80000000 and 0x00000000 in words 14–15. Block 2 is 14×0, then 0x00000000, 0x000001c0, with use_prev_cv=1. Final CV = 84983e44 1c3bd26e baae4aa1 f95129e5 e54670f1.
- 55-byte message (last beat in_bytes=3) → single block; word 13 ends in 0x80; length 0x000001b8; exactly one core_start.
- 64-byte message (16 full beats) → second block = 0x80000000, 13×0, 0x00000000, 0x00000200. in_ready stays 0 throughout WAIT.
- Backpressure and abort: in_valid toggles every other cycle → word order preserved, no duplicate core_load. reset_n=0 asserted mid-block → all outputs 0 within the same cycle. A subsequent "abc" still produces the correct digest.
- With SHA1_PAD_EMPTY_MSG_EN: empty message → words 0x80000000, 15×0. Digest = da39a3ee 5e6b4b0d 3255bfef 95601890 afd80709.
